// File: rtl/demux_l2_lane_fifo_pkg.sv
// Shared defaults and helpers for the two-lane L2 demux receive FIFO.
// The pointer width helper is used by every lane instance.
package demux_l2_lane_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_AF_THRESH = 3;

  // log2 of the lane depth, never narrower than one bit
  function automatic int ptr_width(input int depth);
    if (depth < 2) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/demux_l2_lane_fifo_if.sv
// Lane-side bus of the two-lane FIFO: write strobes/data from the L2 demux,
// read requests from downstream, and per-lane read data and status flags.
interface demux_l2_lane_fifo_if
  import demux_l2_lane_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             validin0;
  logic             validin1;
  logic [WIDTH-1:0] datain0;
  logic [WIDTH-1:0] datain1;
  logic             pop0;
  logic             pop1;
  logic             validout0;
  logic             validout1;
  logic [WIDTH-1:0] dataout0;
  logic [WIDTH-1:0] dataout1;
  logic             empty0;
  logic             empty1;
  logic             full0;
  logic             full1;
  logic             almost_full0;
  logic             almost_full1;
  logic             overflow0;
  logic             overflow1;
  logic             underflow0;
  logic             underflow1;

  modport master (
    output validin0, validin1, datain0, datain1, pop0, pop1,
    input  validout0, validout1, dataout0, dataout1,
    input  empty0, empty1, full0, full1, almost_full0, almost_full1,
    input  overflow0, overflow1, underflow0, underflow1
  );

  modport slave (
    input  validin0, validin1, datain0, datain1, pop0, pop1,
    output validout0, validout1, dataout0, dataout1,
    output empty0, empty1, full0, full1, almost_full0, almost_full1,
    output overflow0, overflow1, underflow0, underflow1
  );

endinterface

// File: rtl/lane_fifo.sv
// One lane of the L2 demux FIFO: occupancy-counted circular buffer with a
// registered one-cycle read port, occupancy flags and sticky error flags.
module lane_fifo
  import demux_l2_lane_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             validin_i,
  input  logic [WIDTH-1:0] datain_i,
  input  logic             pop_i,
  output logic             validout_o,
  output logic [WIDTH-1:0] dataout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int             PW       = ptr_width(DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]    AF_CNT   = 32'(AF_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             validout_q, validout_d;
  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic             empty_q, full_q, almost_full_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok_s, pop_ok_s;

  // Accept/reject decisions and next-state; a full lane still takes a push when a pop frees a slot
  always_comb begin
    pop_ok_s    = !rst_i && pop_i && (count_q != {CW{1'b0}});
    push_ok_s   = !rst_i && validin_i && ((count_q != FULL_CNT) || pop_ok_s);
    wr_ptr_d    = push_ok_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_ok_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    validout_d  = pop_ok_s;
    dataout_d   = pop_ok_s ? mem_q[rd_ptr_q] : dataout_q;
    overflow_d  = overflow_q  | (validin_i && !push_ok_s);
    underflow_d = underflow_q | (pop_i && !pop_ok_s);
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Lane state, read port and flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q       <= {CW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      validout_q    <= 1'b0;
      dataout_q     <= {WIDTH{1'b0}};
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      validout_q    <= validout_d;
      dataout_q     <= dataout_d;
      empty_q       <= (count_d == {CW{1'b0}});
      full_q        <= (count_d == FULL_CNT);
      almost_full_q <= ({{(32-CW){1'b0}}, count_d} >= AF_CNT);
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Storage needs no reset: dataout only ever samples slots that were written
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= datain_i;
    end
  end

  assign validout_o    = validout_q;
  assign dataout_o     = dataout_q;
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign almost_full_o = almost_full_q;
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;

endmodule

// File: rtl/demux_l2_lane_fifo.sv
// Two independent lane FIFOs behind the L2 demux; wiring only.
module demux_l2_lane_fifo
  import demux_l2_lane_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH
) (
  input logic                 clk_4f,
  input logic                 reset_L,
  demux_l2_lane_fifo_if.slave bus
);

  lane_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_lane0 (
    .clk_i         (clk_4f),
    .rst_i         (reset_L),
    .validin_i     (bus.validin0),
    .datain_i      (bus.datain0),
    .pop_i         (bus.pop0),
    .validout_o    (bus.validout0),
    .dataout_o     (bus.dataout0),
    .empty_o       (bus.empty0),
    .full_o        (bus.full0),
    .almost_full_o (bus.almost_full0),
    .overflow_o    (bus.overflow0),
    .underflow_o   (bus.underflow0)
  );

  lane_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_lane1 (
    .clk_i         (clk_4f),
    .rst_i         (reset_L),
    .validin_i     (bus.validin1),
    .datain_i      (bus.datain1),
    .pop_i         (bus.pop1),
    .validout_o    (bus.validout1),
    .dataout_o     (bus.dataout1),
    .empty_o       (bus.empty1),
    .full_o        (bus.full1),
    .almost_full_o (bus.almost_full1),
    .overflow_o    (bus.overflow1),
    .underflow_o   (bus.underflow1)
  );

endmodule

// File: tb/tb_demux_l2_lane_fifo.sv
// Directed bench for demux_l2_lane_fifo: a queue-based lane model checked
// against every output each cycle, plus literal expectations per scenario.
module tb_demux_l2_lane_fifo;
  import demux_l2_lane_fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;

  logic clk_4f  = 1'b0;
  logic reset_L = 1'b1;

  demux_l2_lane_fifo_if #(.WIDTH(W)) bus ();

  demux_l2_lane_fifo #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AF)
  ) dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_4f = ~clk_4f;

  int n_cmp  = 0;
  int n_fail = 0;

  // model: per-lane queue of stored data, last read word, sticky errors
  logic [W-1:0] mq [2][$];
  bit           mv [2];
  logic [W-1:0] md [2];
  bit           movf [2];
  bit           mudf [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit v[2], input logic [W-1:0] d[2], input bit p[2]);
    bit pa;
    bit va;
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        mq[l].delete();
        mv[l]   = 1'b0;
        md[l]   = '0;
        movf[l] = 1'b0;
        mudf[l] = 1'b0;
      end else begin
        pa = p[l] && (mq[l].size() > 0);
        va = v[l] && ((mq[l].size() < D) || pa);
        mv[l] = pa;
        if (pa) md[l] = mq[l].pop_front();
        if (va) mq[l].push_back(d[l]);
        if (v[l] && !va) movf[l] = 1'b1;
        if (p[l] && !pa) mudf[l] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("validout0",    bus.validout0,    mv[0]);
    chk("dataout0",     bus.dataout0,     md[0]);
    chk("empty0",       bus.empty0,       mq[0].size() == 0);
    chk("full0",        bus.full0,        mq[0].size() == D);
    chk("almost_full0", bus.almost_full0, mq[0].size() >= AF);
    chk("overflow0",    bus.overflow0,    movf[0]);
    chk("underflow0",   bus.underflow0,   mudf[0]);
    chk("validout1",    bus.validout1,    mv[1]);
    chk("dataout1",     bus.dataout1,     md[1]);
    chk("empty1",       bus.empty1,       mq[1].size() == 0);
    chk("full1",        bus.full1,        mq[1].size() == D);
    chk("almost_full1", bus.almost_full1, mq[1].size() >= AF);
    chk("overflow1",    bus.overflow1,    movf[1]);
    chk("underflow1",   bus.underflow1,   mudf[1]);
  endtask

  // Apply one cycle of inputs, let the edge pass, then advance the model and compare
  task automatic st(input bit rst, input bit v0, input logic [W-1:0] d0, input bit p0,
                    input bit v1, input logic [W-1:0] d1, input bit p1);
    bit           v [2];
    logic [W-1:0] d [2];
    bit           p [2];
    reset_L      = rst;
    bus.validin0 = v0;
    bus.datain0  = d0;
    bus.pop0     = p0;
    bus.validin1 = v1;
    bus.datain1  = d1;
    bus.pop1     = p1;
    @(negedge clk_4f);
    v[0] = v0; d[0] = d0; p[0] = p0;
    v[1] = v1; d[1] = d1; p[1] = p1;
    model_step(rst, v, d, p);
    compare_all();
  endtask

  initial begin
    logic [W-1:0] exp_drain [4];

    // reset state
    st(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_empty0", bus.empty0, 32'd1);
    chk("rst_full0", bus.full0, 32'd0);
    chk("rst_dataout0", bus.dataout0, 32'h00);

    // lane 0: three pushes then three pops
    st(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
    st(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
    st(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("l0_af_at3", bus.almost_full0, 32'd1);
    chk("l1_empty", bus.empty1, 32'd1);
    st(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("l0_pop_11", bus.dataout0, 32'h11);
    st(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("l0_pop_22", bus.dataout0, 32'h22);
    st(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("l0_pop_33", bus.dataout0, 32'h33);
    st(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("l0_idle_valid", bus.validout0, 32'd0);
    chk("l0_idle_hold", bus.dataout0, 32'h33);

    // lane 1: overfill, drain, underflow
    for (int i = 0; i < 5; i++) begin
      st(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
      if (i == 3) chk("l1_full_after4", bus.full1, 32'd1);
    end
    chk("l1_overflow", bus.overflow1, 32'd1);
    for (int i = 0; i < 4; i++) begin
      st(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("l1_drain", bus.dataout1, 32'(8'hA0 + i));
    end
    st(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("l1_underflow", bus.underflow1, 32'd1);
    chk("l1_udf_valid", bus.validout1, 32'd0);

    // push+pop on an empty lane accepts only the push
    st(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1);
    chk("l1_pp_empty_valid", bus.validout1, 32'd0);
    chk("l1_pp_empty_notempty", bus.empty1, 32'd0);
    st(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("l1_pp_empty_data", bus.dataout1, 32'h77);

    // lane 0 full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) st(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
    chk("l0_full", bus.full0, 32'd1);
    st(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("l0_fullpp_data", bus.dataout0, 32'h01);
    chk("l0_fullpp_full", bus.full0, 32'd1);
    chk("l0_fullpp_ovf", bus.overflow0, 32'd0);
    exp_drain[0] = 8'h02; exp_drain[1] = 8'h03; exp_drain[2] = 8'h04; exp_drain[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      st(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("l0_fullpp_drain", bus.dataout0, 32'(exp_drain[i]));
    end

    // pointer wrap with streaming push/pop pairs
    st(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i < 10; i++) begin
      st(1'b0, 1'b1, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
      chk("l0_wrap", bus.dataout0, 32'(i - 1));
    end
    st(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("l0_wrap_last", bus.dataout0, 32'h09);
    chk("l0_wrap_empty", bus.empty0, 32'd1);

    // mid-operation reset with busy inputs
    st(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0);
    st(1'b0, 1'b1, 8'hC2, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_rst_ovf1", bus.overflow1, 32'd1);
    st(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 8'hEE, 1'b1);
    chk("mid_rst_empty0", bus.empty0, 32'd1);
    chk("mid_rst_valid0", bus.validout0, 32'd0);
    chk("mid_rst_data0", bus.dataout0, 32'h00);
    chk("mid_rst_ovf1", bus.overflow1, 32'd0);
    chk("mid_rst_udf1", bus.underflow1, 32'd0);
    chk("mid_rst_af0", bus.almost_full0, 32'd0);
    st(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_udf0", bus.underflow0, 32'd1);
    chk("post_rst_data0", bus.dataout0, 32'h00);
    st(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0);
    st(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_data99", bus.dataout0, 32'h99);
    st(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_l2_lane_fifo.md
DEMUX_L2_LANE_FIFO -- requirements
Module: demux_l2_lane_fifo

Interface
REQ-001 Parameter WIDTH, default 8, lane data width in bits.
REQ-002 Parameter DEPTH, default 4, entries per lane FIFO; power of two, at least 2.
REQ-003 Parameter AF_THRESH, default 3, occupancy at or above which almost_full asserts.
REQ-004 clk_4f  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_L  input  1  synchronous, active-high reset.
REQ-006 validin0, validin1  input  1 each  lane write strobes from the L2 demux.
REQ-007 datain0, datain1  input  WIDTH each  lane write data from the L2 demux.
REQ-008 pop0, pop1  input  1 each  downstream read requests, one per lane.
REQ-009 validout0, validout1  output  1 each  registered read-data qualifiers.
REQ-010 dataout0, dataout1  output  WIDTH each  registered read data.
REQ-011 empty0/1, full0/1, almost_full0/1  output  1 each  per-lane occupancy flags.
REQ-012 overflow0/1, underflow0/1  output  1 each  sticky per-lane error flags.

Function
REQ-013 Lanes SHALL be fully independent; lane 0 activity never affects lane 1 state, and vice versa.
REQ-014 Each lane SHALL track occupancy count in 0..DEPTH and keep wr_ptr and rd_ptr modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-015 Push SHALL be accepted when validin=1 and either (count<DEPTH) or (pop accepted in the same cycle).
REQ-016 Pop SHALL be accepted when pop=1 and count>0; no same-cycle bypass: push+pop when empty accepts only the push.
REQ-017 On an accepted pop, the next cycle SHALL show validout=1 and dataout=entry at rd_ptr (1-cycle read latency).
REQ-018 In cycles after no accepted pop, validout SHALL be 0 and dataout SHALL hold its last value.
REQ-019 Accepted push and pop together SHALL leave count unchanged and advance both pointers.
REQ-020 empty=(count==0), full=(count==DEPTH), almost_full=(count>=AF_THRESH), all derived from registered count.
REQ-021 A push rejected because full (validin=1, count==DEPTH, no pop) SHALL drop the data and set overflow, which stays set until reset.
REQ-022 pop=1 with count==0 SHALL set underflow, sticky until reset; state otherwise unchanged.
REQ-023 Data SHALL leave each lane in exact arrival order with no duplication or loss except per REQ-021.

Reset
REQ-024 While reset_L=1 at a clock edge: count=0, pointers=0, validout=0, dataout=0, overflow=0, underflow=0, empty=1, full=0, almost_full=0.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries; inputs in that cycle SHALL be ignored.
REQ-026 Storage array contents need not be reset; they SHALL never be visible on dataout before being written.

Structure
REQ-027 A shared package SHALL hold default WIDTH, DEPTH, AF_THRESH and a function for pointer width (log2 DEPTH).
REQ-028 One sub-module, lane_fifo, SHALL implement a single lane and SHALL be instantiated twice.
REQ-029 Top level SHALL contain no logic beyond the two instances and port wiring.

Verification
REQ-030 Reset, then push 0x11,0x22,0x33 on lane 0 -> count 3, almost_full0=1, empty1=1; pop0 three cycles -> dataout0 0x11,0x22,0x33 one cycle after each pop.
REQ-031 Push 0xA0..0xA4 on lane 1 with no pop -> full1=1 after 4; 0xA4 dropped, overflow1=1; drain yields 0xA0..0xA3.
REQ-032 Lane 0 full, simultaneous validin0=1 (0x55) and pop0=1 -> push accepted, count stays 4, overflow0=0; 0x55 emerges last.
REQ-033 pop1=1 while empty1=1 -> underflow1=1, validout1=0; push+pop same cycle on empty lane -> count 1, validout1=0.
REQ-034 Run 10 push/pop pairs on lane 0 (values 0x00..0x09) -> pointers wrap twice, output order 0x00..0x09, lane 1 untouched.
REQ-035 Assert reset_L with lane 0 holding 2 entries and overflow1=1 -> next cycle all outputs match REQ-024.
